// File: rtl/shift_pipe_if.sv
// Operation/result handshake bundle for shift_pipe.
// The master issues shift operations and consumes results; the slave side is the shifter.
interface shift_pipe_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_tag
    );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROR) with tag sideband,
// global-advance valid/ready handshake and synchronous flush.
module shift_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    shift_pipe_if.slave bus
);
    localparam int unsigned AMT_W = $clog2(WIDTH);
    localparam int unsigned IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [WIDTH-1:0] ONES = '1;

    // One shift level of 2^k positions; SRA fills with the sign captured at input.
    function automatic logic [WIDTH-1:0] level_shift(
        input logic [WIDTH-1:0] d,
        input int unsigned      sh,
        input logic [1:0]       mode,
        input logic             sign
    );
        logic [WIDTH-1:0] res;
        res = d;
        case (mode)
            2'b00:   res = d << sh;
            2'b01:   res = d >> sh;
            2'b10:   res = (d >> sh) | (sign ? ~(ONES >> sh) : '0);
            default: res = (d >> sh) | (d << (WIDTH - sh));
        endcase
        return res;
    endfunction

    // Applies only the levels k that map onto this stage: floor(k*STAGES/L) == stage.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [AMT_W-1:0] amt,
        input logic [1:0]       mode,
        input logic             sign,
        input int unsigned      stage
    );
        logic [WIDTH-1:0] res;
        logic [AMT_W-1:0] bits;
        res  = d;
        bits = '0;
        for (int unsigned k = 0; k < AMT_W; k++) begin
            bits = amt >> k;
            if ((((k * STAGES) / AMT_W) == stage) && bits[0]) begin
                res = level_shift(res, 32'd1 << k, mode, sign);
            end
        end
        return res;
    endfunction

    logic [STAGES-1:0][WIDTH-1:0] r_data;
    logic [STAGES-1:0][AMT_W-1:0] r_amt;
    logic [STAGES-1:0][1:0]       r_mode;
    logic [STAGES-1:0]            r_sign;
    logic [STAGES-1:0][TAG_W-1:0] r_tag;
    logic [STAGES-1:0]            r_valid;
    logic                         r_zero;

    logic [STAGES-1:0][WIDTH-1:0] w_src_data;
    logic [STAGES-1:0][AMT_W-1:0] w_src_amt;
    logic [STAGES-1:0][1:0]       w_src_mode;
    logic [STAGES-1:0]            w_src_sign;
    logic [STAGES-1:0][TAG_W-1:0] w_src_tag;
    logic [STAGES-1:0]            w_src_valid;
    logic [STAGES-1:0][WIDTH-1:0] w_nxt_data;
    logic                         w_advance;

    // Stage inputs: stage 0 from the port, stage s from register s-1; then apply its levels.
    always_comb begin
        w_src_data  = '0;
        w_src_amt   = '0;
        w_src_mode  = '0;
        w_src_sign  = '0;
        w_src_tag   = '0;
        w_src_valid = '0;
        w_nxt_data  = '0;

        w_src_data[0]  = bus.in_data;
        w_src_amt[0]   = bus.in_amt;
        w_src_mode[0]  = bus.in_mode;
        w_src_sign[0]  = bus.in_data[WIDTH-1];
        w_src_tag[0]   = bus.in_tag;
        w_src_valid[0] = bus.in_valid;

        for (int unsigned s = 1; s < STAGES; s++) begin
            w_src_data[IDX_W'(s)]  = r_data[IDX_W'(s - 1)];
            w_src_amt[IDX_W'(s)]   = r_amt[IDX_W'(s - 1)];
            w_src_mode[IDX_W'(s)]  = r_mode[IDX_W'(s - 1)];
            w_src_sign[IDX_W'(s)]  = r_sign[IDX_W'(s - 1)];
            w_src_tag[IDX_W'(s)]   = r_tag[IDX_W'(s - 1)];
            w_src_valid[IDX_W'(s)] = r_valid[IDX_W'(s - 1)];
        end

        for (int unsigned s = 0; s < STAGES; s++) begin
            w_nxt_data[IDX_W'(s)] = stage_shift(w_src_data[IDX_W'(s)], w_src_amt[IDX_W'(s)],
                                                w_src_mode[IDX_W'(s)], w_src_sign[IDX_W'(s)], s);
        end
    end

    assign w_advance = !r_valid[IDX_W'(STAGES - 1)] || bus.out_ready;

    // Whole pipe moves together; flush kills every valid bit and overrides a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_amt   <= '0;
            r_mode  <= '0;
            r_sign  <= '0;
            r_tag   <= '0;
            r_valid <= '0;
            r_zero  <= 1'b0;
        end else begin
            if (w_advance) begin
                r_data  <= w_nxt_data;
                r_amt   <= w_src_amt;
                r_mode  <= w_src_mode;
                r_sign  <= w_src_sign;
                r_tag   <= w_src_tag;
                r_valid <= w_src_valid;
                r_zero  <= (w_nxt_data[IDX_W'(STAGES - 1)] == '0);
            end
            if (flush) begin
                r_valid <= '0;
            end
        end
    end

    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_valid[IDX_W'(STAGES - 1)];
    assign bus.out_data  = r_data[IDX_W'(STAGES - 1)];
    assign bus.out_zero  = r_zero;
    assign bus.out_tag   = r_tag[IDX_W'(STAGES - 1)];
endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed 16-bit/2-stage scenarios plus randomized
// 32-bit runs at 1, 3 and 5 stages checked against a queue-based model.
module tb_shift_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush16 = 1'b0;
    logic rand_go = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        int unsigned rem;
    } exp_t;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference on a w-bit operand.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int unsigned amt,
                                              input logic [1:0] mode, input int unsigned w);
        logic [63:0] mask, x, r;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, d} & mask;
        case (mode)
            2'd0:    r = (x << amt) & mask;
            2'd1:    r = x >> amt;
            2'd2:    r = (x >> amt) | ((((x >> (w - 1)) & 64'd1) != 64'd0) ? (mask & ~(mask >> amt)) : 64'd0);
            default: r = ((x >> amt) | (x << (w - amt))) & mask;
        endcase
        return r[31:0];
    endfunction

    shift_pipe_if #(.WIDTH(16), .TAG_W(4)) if16 ();
    shift_pipe #(.WIDTH(16), .STAGES(2), .TAG_W(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush16),
        .bus   (if16)
    );

    task automatic drive16(input logic v, input logic [15:0] d, input logic [3:0] a,
                           input logic [1:0] m, input logic [3:0] t);
        if16.in_valid = v;
        if16.in_data  = d;
        if16.in_amt   = a;
        if16.in_mode  = m;
        if16.in_tag   = t;
    endtask

    // Randomized 32-bit instances; each item becomes visible after STAGES advancing edges.
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int unsigned S = 1 + 2 * g;
        logic done = 1'b0;
        exp_t q[$];

        shift_pipe_if #(.WIDTH(32), .TAG_W(4)) bif ();
        shift_pipe #(.WIDTH(32), .STAGES(S), .TAG_W(4)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (1'b0),
            .bus   (bif)
        );

        initial begin
            logic        exp_v;
            logic        adv;
            logic [3:0]  t;
            exp_t        e;
            t = 4'd0;
            bif.in_valid  = 1'b0;
            bif.in_data   = '0;
            bif.in_amt    = '0;
            bif.in_mode   = '0;
            bif.in_tag    = '0;
            bif.out_ready = 1'b0;
            wait (rand_go);
            for (int cyc = 0; cyc < 420; cyc++) begin
                @(negedge clk);
                exp_v = (q.size() > 0) && (q[0].rem == 0);
                check_eq($sformatf("s%0d_valid_c%0d", S, cyc), 64'(bif.out_valid), 64'(exp_v));
                if (exp_v) begin
                    check_eq($sformatf("s%0d_data_c%0d", S, cyc), 64'(bif.out_data), 64'(q[0].d));
                    check_eq($sformatf("s%0d_zero_c%0d", S, cyc), 64'(bif.out_zero), 64'(q[0].d == 32'd0));
                    check_eq($sformatf("s%0d_tag_c%0d", S, cyc), 64'(bif.out_tag), 64'(q[0].t));
                end
                if (cyc < 400) begin
                    bif.out_ready = ($urandom_range(0, 3) != 0);
                    bif.in_valid  = ($urandom_range(0, 3) != 0);
                end else begin
                    bif.out_ready = 1'b1;
                    bif.in_valid  = 1'b0;
                end
                bif.in_data = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom());
                bif.in_amt  = 5'($urandom_range(0, 31));
                bif.in_mode = 2'($urandom_range(0, 3));
                bif.in_tag  = t;
                #1;
                adv = !exp_v || bif.out_ready;
                check_eq($sformatf("s%0d_ready_c%0d", S, cyc), 64'(bif.in_ready), 64'(adv));
                if (adv) begin
                    if (exp_v) void'(q.pop_front());
                    foreach (q[i]) if (q[i].rem > 0) q[i].rem--;
                    if (bif.in_valid) begin
                        e.d   = ref_shift(bif.in_data, int'(bif.in_amt), bif.in_mode, 32);
                        e.t   = t;
                        e.rem = S - 1;
                        q.push_back(e);
                        t++;
                    end
                end
            end
            check_eq($sformatf("s%0d_drained", S), 64'(q.size()), 64'd0);
            done = 1'b1;
        end
    end

    localparam int N_DIR = 9;
    logic [15:0] dir_d   [N_DIR] = '{16'h0001, 16'h8000, 16'h8000, 16'h1234, 16'h00F0,
                                     16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    logic [3:0]  dir_a   [N_DIR] = '{4'd15, 4'd15, 4'd4, 4'd4, 4'd12, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [1:0]  dir_m   [N_DIR] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [15:0] dir_exp [N_DIR] = '{16'h8000, 16'h0001, 16'hF800, 16'h4123, 16'h0000,
                                     16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};

    initial begin
        int          sent;
        int          got;
        logic        stalled;
        logic        ordy;
        logic [15:0] hold_d;
        logic [3:0]  hold_t;
        logic [15:0] ed;

        drive16(1'b0, 16'h0, 4'h0, 2'd0, 4'h0);
        if16.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 64'(if16.out_valid), 64'd0);
        check_eq("rst_data", 64'(if16.out_data), 64'd0);
        check_eq("rst_zero", 64'(if16.out_zero), 64'd0);
        check_eq("rst_tag", 64'(if16.out_tag), 64'd0);
        check_eq("rst_ready", 64'(if16.in_ready), 64'd1);
        rst_n = 1'b1;

        // Mode sweep, zero and identity: back-to-back, each result two cycles later.
        for (int i = 0; i < N_DIR + 3; i++) begin
            @(negedge clk);
            if (i >= 2 && i - 2 < N_DIR) begin
                check_eq($sformatf("sweep%0d_valid", i - 2), 64'(if16.out_valid), 64'd1);
                check_eq($sformatf("sweep%0d_data", i - 2), 64'(if16.out_data), 64'(dir_exp[i - 2]));
                check_eq($sformatf("sweep%0d_zero", i - 2), 64'(if16.out_zero), 64'(dir_exp[i - 2] == 16'h0));
                check_eq($sformatf("sweep%0d_tag", i - 2), 64'(if16.out_tag), 64'(i - 1));
            end else begin
                check_eq($sformatf("sweep_idle%0d", i), 64'(if16.out_valid), 64'd0);
            end
            check_eq($sformatf("sweep_ready%0d", i), 64'(if16.in_ready), 64'd1);
            if (i < N_DIR) drive16(1'b1, dir_d[i], dir_a[i], dir_m[i], 4'(i + 1));
            else           drive16(1'b0, 16'h0, 4'h0, 2'd0, 4'h0);
        end

        // Backpressure: tags 1..6, out_ready low for three cycles mid-stream.
        sent = 0; got = 0; stalled = 1'b0; hold_d = '0; hold_t = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stalled) begin
                check_eq($sformatf("bp_hold_data%0d", i), 64'(if16.out_data), 64'(hold_d));
                check_eq($sformatf("bp_hold_tag%0d", i), 64'(if16.out_tag), 64'(hold_t));
            end
            ordy = !(i >= 4 && i <= 6);
            if16.out_ready = ordy;
            drive16(sent < 6, 16'h0001, 4'(sent + 1), 2'd0, 4'(sent + 1));
            #1;
            if (if16.out_valid) begin
                if (!ordy) begin
                    check_eq($sformatf("bp_stall_ready%0d", i), 64'(if16.in_ready), 64'd0);
                end else begin
                    ed = 16'h0001 << (got + 1);
                    check_eq($sformatf("bp_tag%0d", got + 1), 64'(if16.out_tag), 64'(got + 1));
                    check_eq($sformatf("bp_data%0d", got + 1), 64'(if16.out_data), 64'(ed));
                    got++;
                end
            end
            stalled = if16.out_valid && !ordy;
            hold_d  = if16.out_data;
            hold_t  = if16.out_tag;
            if (if16.in_valid && if16.in_ready) sent++;
        end
        check_eq("bp_sent", 64'(sent), 64'd6);
        check_eq("bp_got", 64'(got), 64'd6);
        @(negedge clk);
        drive16(1'b0, 16'h0, 4'h0, 2'd0, 4'h0);
        check_eq("bp_empty", 64'(if16.out_valid), 64'd0);

        // Flush together with a stall and a third in_valid.
        @(negedge clk);
        if16.out_ready = 1'b0;
        drive16(1'b1, 16'h00FF, 4'd1, 2'd3, 4'hA);
        @(negedge clk);
        drive16(1'b1, 16'h0F0F, 4'd2, 2'd1, 4'hB);
        @(negedge clk);
        check_eq("fl_pre_valid", 64'(if16.out_valid), 64'd1);
        check_eq("fl_pre_tag", 64'(if16.out_tag), 64'hA);
        drive16(1'b1, 16'h1111, 4'd3, 2'd0, 4'hC);
        flush16 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            flush16 = 1'b0;
            if16.out_ready = 1'b1;
            drive16(1'b0, 16'h0, 4'h0, 2'd0, 4'h0);
            check_eq($sformatf("fl_valid%0d", i), 64'(if16.out_valid), 64'd0);
        end

        // Asynchronous reset with two operations in flight.
        @(negedge clk);
        drive16(1'b1, 16'h0003, 4'd1, 2'd0, 4'h1);
        @(negedge clk);
        drive16(1'b1, 16'h0006, 4'd1, 2'd0, 4'h2);
        @(negedge clk);
        drive16(1'b0, 16'h0, 4'h0, 2'd0, 4'h0);
        #1;
        check_eq("ar_pre_valid", 64'(if16.out_valid), 64'd1);
        check_eq("ar_pre_data", 64'(if16.out_data), 64'h0006);
        #1 rst_n = 1'b0;
        #1;
        check_eq("ar_valid", 64'(if16.out_valid), 64'd0);
        check_eq("ar_data", 64'(if16.out_data), 64'd0);
        check_eq("ar_zero", 64'(if16.out_zero), 64'd0);
        check_eq("ar_tag", 64'(if16.out_tag), 64'd0);
        check_eq("ar_ready", 64'(if16.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ar_post_idle", 64'(if16.out_valid), 64'd0);
        drive16(1'b1, 16'hFFFF, 4'd15, 2'd2, 4'h9);
        @(negedge clk);
        check_eq("ar_post_lat1", 64'(if16.out_valid), 64'd0);
        drive16(1'b0, 16'h0, 4'h0, 2'd0, 4'h0);
        @(negedge clk);
        check_eq("ar_post_valid", 64'(if16.out_valid), 64'd1);
        check_eq("ar_post_data", 64'(if16.out_data), 64'hFFFF);
        check_eq("ar_post_zero", 64'(if16.out_zero), 64'd0);
        check_eq("ar_post_tag", 64'(if16.out_tag), 64'h9);
        @(negedge clk);
        check_eq("ar_post_done", 64'(if16.out_valid), 64'd0);

        // Randomized 32-bit parameter sweep.
        rand_go = 1'b1;
        for (int i = 0; i < 2000 && !(g_rand[0].done && g_rand[1].done && g_rand[2].done); i++) begin
            @(posedge clk);
        end
        check_eq("rand_done", 64'({g_rand[2].done, g_rand[1].done, g_rand[0].done}), 64'h7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
